// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// Raster timing generator: free-running h/v counters drive HS/VS/BLANK; active pixels come from a show-ahead FIFO.
// Outputs are registered one clock behind the counters; the FIFO is never stalled, so an empty head yields black plus sticky underflow.
module video_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_rinc,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_blank,
  output logic [23:0] video_rgb,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          active;
  logic          frame_origin;
  logic          streaming;
  logic          hs_low;
  logic          vs_low;
  logic          rdata_unused;

  assign rdata_unused = ^fifo_rdata[31:24];

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign active       = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign frame_origin = (hcnt == '0) && (vcnt == '0);
  assign hs_low       = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
  assign vs_low       = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);

  // ARMED already streams on the frame-origin cycle so pixel (0,0) is not lost.
  assign streaming = (state == ST_RUN) || ((state == ST_ARMED) && frame_origin);
  assign fifo_rinc = streaming && active && !fifo_empty && !pixel_rst;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fifo_full) state_nxt = ST_ARMED;
      ST_ARMED: if (frame_origin) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      video_hs    <= 1'b1;
      video_vs    <= 1'b1;
      video_blank <= 1'b0;
      video_rgb   <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      video_hs    <= !hs_low;
      video_vs    <= !vs_low;
      video_blank <= active;
      video_rgb   <= fifo_rinc ? fifo_rdata[23:0] : '0;
      frame_start <= frame_origin;
      if (streaming && active && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Directed bench for video_timing_gen at 160x90 active; tick() advances one clock and models the show-ahead FIFO head.
module tb_video_timing_gen;

  localparam int HD    = 160;
  localparam int VD    = 90;
  localparam int HT    = 288;
  localparam int VT    = 135;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BASE = 24'h400000;

  logic        pixel_clk;
  logic        pixel_rst;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_rinc;
  logic        video_hs;
  logic        video_vs;
  logic        video_blank;
  logic [23:0] video_rgb;
  logic        frame_start;
  logic        underflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   word = 0;
  int   vs_fall_first = -1;
  logic pop_q = 1'b0;

  video_timing_gen #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_rinc  (fifo_rinc),
    .video_hs   (video_hs),
    .video_vs   (video_vs),
    .video_blank(video_blank),
    .video_rgb  (video_rgb),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  // After tick number k the registered outputs show raster position k-1.
  task automatic tick();
    @(negedge pixel_clk);
    pop_q = fifo_rinc;
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (pop_q === 1'b1) begin
      word++;
      fifo_rdata = {8'hA5, BASE + 24'(word)};
    end
  endtask

  task automatic test_reset();
    pixel_rst  = 1'b1;
    fifo_empty = 1'b1;
    fifo_full  = 1'b0;
    fifo_rdata = {8'hA5, BASE};
    #12;
    checks++; if (video_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b want 1", video_hs); end
    checks++; if (video_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b want 1", video_vs); end
    checks++; if (video_blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %b want 0", video_blank); end
    checks++; if (video_rgb !== 24'd0) begin errors++; $display("FAIL reset_rgb got %h want 0", video_rgb); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
    checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", fifo_rinc); end
    @(posedge pixel_clk);
    #2;
    pixel_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_free_run();
    int   p;
    int   hs_fall0 = -1, hs_fall1 = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    int   blank_cnt = 0, rgb_nz = 0, pops = 0, uf = 0, fs_cnt = 0, fs_pos = -1, vs_mis = 0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    while (cyc < 30800) begin
      tick();
      p = cyc - 1;
      if (prev_hs && !video_hs) begin
        if (hs_fall0 < 0) hs_fall0 = p;
        else if (hs_fall1 < 0) hs_fall1 = p;
      end
      if (!prev_hs && video_hs && hs_rise < 0) hs_rise = p;
      if (prev_vs && !video_vs && vs_fall < 0) vs_fall = p;
      if (!prev_vs && video_vs && vs_rise < 0) vs_rise = p;
      if ((video_vs !== prev_vs) && ((p % HT) != 0)) vs_mis++;
      if (video_blank) blank_cnt++;
      if (video_rgb !== 24'd0) rgb_nz++;
      if (pop_q) pops++;
      if (underflow !== 1'b0) uf++;
      if (frame_start) begin fs_cnt++; fs_pos = p; end
      prev_hs = video_hs;
      prev_vs = video_vs;
    end
    vs_fall_first = vs_fall;
    checks++; if (hs_fall0 != 200) begin errors++; $display("FAIL hs_first_fall got %0d want 200", hs_fall0); end
    checks++; if (hs_fall1 - hs_fall0 != 288) begin errors++; $display("FAIL hs_period got %0d want 288", hs_fall1 - hs_fall0); end
    checks++; if (hs_rise - hs_fall0 != 48) begin errors++; $display("FAIL hs_width got %0d want 48", hs_rise - hs_fall0); end
    checks++; if (vs_fall != 29664) begin errors++; $display("FAIL vs_first_fall got %0d want 29664", vs_fall); end
    checks++; if (vs_rise - vs_fall != 864) begin errors++; $display("FAIL vs_width got %0d want 864", vs_rise - vs_fall); end
    checks++; if (vs_mis != 0) begin errors++; $display("FAIL vs_line_aligned got %0d want 0", vs_mis); end
    checks++; if (blank_cnt != 14400) begin errors++; $display("FAIL active_pixels got %0d want 14400", blank_cnt); end
    checks++; if (rgb_nz != 0) begin errors++; $display("FAIL idle_rgb_nonzero got %0d want 0", rgb_nz); end
    checks++; if (pops != 0) begin errors++; $display("FAIL idle_pops got %0d want 0", pops); end
    checks++; if (uf != 0) begin errors++; $display("FAIL idle_underflow got %0d want 0", uf); end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d want 1", fs_cnt); end
    checks++; if (fs_pos != 0) begin errors++; $display("FAIL frame_start_pos got %0d want 0", fs_pos); end
  endtask

  task automatic test_arm_pulse();
    int pops = 0, rgb_nz = 0;
    word       = 0;
    fifo_rdata = {8'hA5, BASE};
    fifo_empty = 1'b0;
    fifo_full  = 1'b1;
    tick();
    if (pop_q) pops++;
    fifo_full = 1'b0;
    while (cyc < FRAME) begin
      tick();
      if (pop_q) pops++;
      if (video_rgb !== 24'd0) rgb_nz++;
    end
    checks++; if (pops != 0) begin errors++; $display("FAIL armed_pops got %0d want 0", pops); end
    checks++; if (rgb_nz != 0) begin errors++; $display("FAIL armed_rgb_nonzero got %0d want 0", rgb_nz); end
    tick();
    checks++; if (pop_q !== 1'b1) begin errors++; $display("FAIL first_pop_at_origin got %b want 1", pop_q); end
    checks++; if (video_rgb !== BASE) begin errors++; $display("FAIL first_pixel_rgb got %h want %h", video_rgb, BASE); end
    checks++; if (video_blank !== 1'b1) begin errors++; $display("FAIL first_pixel_blank got %b want 1", video_blank); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_pixel_frame_start got %b want 1", frame_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL armed_underflow got %b want 0", underflow); end
  endtask

  task automatic test_frame_stream();
    int          exp_idx = 1, px_err = 0, blank_nz = 0, uf = 0, line0 = -1, vs_fall = -1;
    logic [23:0] spot_a = '0, spot_b = '0, spot_c = '0;
    logic        prev_vs;
    prev_vs = video_vs;
    while (cyc < 2 * FRAME) begin
      tick();
      if (video_blank) begin
        if (video_rgb !== BASE + 24'(exp_idx)) px_err++;
        exp_idx++;
      end else if (video_rgb !== 24'd0) begin
        blank_nz++;
      end
      if (cyc == 38886) spot_a = video_rgb;
      if (cyc == 39169) spot_b = video_rgb;
      if (cyc == 64672) spot_c = video_rgb;
      if (cyc == 39168) line0 = word;
      if (prev_vs && !video_vs && vs_fall < 0) vs_fall = cyc - 1;
      if (underflow !== 1'b0) uf++;
      prev_vs = video_vs;
    end
    checks++; if (line0 != 160) begin errors++; $display("FAIL pops_per_line got %0d want 160", line0); end
    checks++; if (word != 14400) begin errors++; $display("FAIL pops_per_frame got %0d want 14400", word); end
    checks++; if (exp_idx != 14400) begin errors++; $display("FAIL active_count got %0d want 14400", exp_idx); end
    checks++; if (px_err != 0) begin errors++; $display("FAIL pixel_order got %0d want 0", px_err); end
    checks++; if (blank_nz != 0) begin errors++; $display("FAIL blank_rgb_nonzero got %0d want 0", blank_nz); end
    checks++; if (spot_a !== BASE + 24'd5) begin errors++; $display("FAIL pixel_5_0 got %h want %h", spot_a, BASE + 24'd5); end
    checks++; if (spot_b !== BASE + 24'd160) begin errors++; $display("FAIL pixel_0_1 got %h want %h", spot_b, BASE + 24'd160); end
    checks++; if (spot_c !== BASE + 24'd14399) begin errors++; $display("FAIL pixel_159_89 got %h want %h", spot_c, BASE + 24'd14399); end
    checks++; if (vs_fall - vs_fall_first != 38880) begin errors++; $display("FAIL vs_period got %0d want 38880", vs_fall - vs_fall_first); end
    checks++; if (uf != 0) begin errors++; $display("FAIL run_underflow got %0d want 0", uf); end
  endtask

  task automatic test_underflow();
    int   bad = 0, uf_drop = 0, hs_fall = -1;
    logic prev_hs;
    while (cyc < 78098) tick();
    checks++; if (video_rgb !== BASE + 24'd14609) begin errors++; $display("FAIL pre_gap_pixel got %h want %h", video_rgb, BASE + 24'd14609); end
    fifo_empty = 1'b1;
    repeat (5) begin
      tick();
      if (pop_q !== 1'b0) bad++;
      if (video_rgb !== 24'd0) bad++;
      if (video_blank !== 1'b1) bad++;
    end
    fifo_empty = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_pixels got %0d want 0", bad); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b want 1", underflow); end
    tick();
    checks++; if (video_rgb !== BASE + 24'd14610) begin errors++; $display("FAIL post_gap_pixel got %h want %h", video_rgb, BASE + 24'd14610); end
    prev_hs = video_hs;
    while (cyc < 78400) begin
      tick();
      if (underflow !== 1'b1) uf_drop++;
      if (prev_hs && !video_hs && hs_fall < 0) hs_fall = cyc - 1;
      prev_hs = video_hs;
    end
    checks++; if (uf_drop != 0) begin errors++; $display("FAIL underflow_sticky got %0d want 0", uf_drop); end
    checks++; if (hs_fall != 78248) begin errors++; $display("FAIL hs_after_underflow got %0d want 78248", hs_fall); end
  endtask

  task automatic test_async_reset();
    int pops = 0, rgb_nz = 0, uf = 0, hs_fall = -1, fs_first = 0;
    logic prev_hs = 1'b1;
    checks++; if (video_blank !== 1'b1) begin errors++; $display("FAIL pre_reset_blank got %b want 1", video_blank); end
    checks++; if (fifo_rinc !== 1'b1) begin errors++; $display("FAIL pre_reset_rinc got %b want 1", fifo_rinc); end
    #2;
    pixel_rst = 1'b1;
    #1;
    checks++; if (video_hs !== 1'b1) begin errors++; $display("FAIL async_hs got %b want 1", video_hs); end
    checks++; if (video_vs !== 1'b1) begin errors++; $display("FAIL async_vs got %b want 1", video_vs); end
    checks++; if (video_blank !== 1'b0) begin errors++; $display("FAIL async_blank got %b want 0", video_blank); end
    checks++; if (video_rgb !== 24'd0) begin errors++; $display("FAIL async_rgb got %h want 0", video_rgb); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL async_frame_start got %b want 0", frame_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL async_underflow got %b want 0", underflow); end
    checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("FAIL async_rinc got %b want 0", fifo_rinc); end
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #2;
    pixel_rst = 1'b0;
    cyc = 0;
    while (cyc < 600) begin
      tick();
      if (pop_q) pops++;
      if (video_rgb !== 24'd0) rgb_nz++;
      if (underflow !== 1'b0) uf++;
      if (cyc == 1 && frame_start === 1'b1) fs_first = 1;
      if (prev_hs && !video_hs && hs_fall < 0) hs_fall = cyc - 1;
      prev_hs = video_hs;
    end
    checks++; if (pops != 0) begin errors++; $display("FAIL post_reset_pops got %0d want 0", pops); end
    checks++; if (rgb_nz != 0) begin errors++; $display("FAIL post_reset_rgb got %0d want 0", rgb_nz); end
    checks++; if (uf != 0) begin errors++; $display("FAIL post_reset_underflow got %0d want 0", uf); end
    checks++; if (fs_first != 1) begin errors++; $display("FAIL post_reset_frame_start got %0d want 1", fs_first); end
    checks++; if (hs_fall != 200) begin errors++; $display("FAIL post_reset_hs got %0d want 200", hs_fall); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_arm_pulse();
    test_frame_stream();
    test_underflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
